// File: rtl/da_param_ctrl.sv
// Parameter update sequencer for the DA waveform path: range-checks frequency/amplitude
// commands and applies them only at waveform wrap boundaries, ramping amplitude one step per wrap.
module da_param_ctrl #(
    parameter logic [15:0] FREQ_MIN  = 16'd1,
    parameter logic [15:0] FREQ_MAX  = 16'd1000,
    parameter logic [15:0] AMP_MAX   = 16'd16,
    parameter logic [15:0] RAMP_STEP = 16'd1,
    parameter logic [15:0] DEF_FREQ  = 16'd100,
    parameter logic [15:0] DEF_AMP   = 16'd1,
    parameter logic [23:0] TIMEOUT   = 24'd5_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [15:0] cmd_freq,
    input  logic [15:0] cmd_amp,
    output logic        cmd_ready,
    input  logic        wrap,
    output logic [15:0] freq_out,
    output logic [15:0] amp_out,
    output logic        busy,
    output logic        upd_done,
    output logic        cmd_err,
    output logic        cmd_drop,
    output logic        tmo
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_WRAP = 2'd1,
        RAMP      = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] pend_freq_reg, pend_freq_next;
    logic [15:0] pend_amp_reg, pend_amp_next;
    logic [23:0] tmr_reg, tmr_next;
    logic [15:0] freq_reg, freq_next;
    logic [15:0] amp_reg, amp_next;
    logic        ready_reg, ready_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic        err_reg, err_next;
    logic        drop_reg, drop_next;
    logic        tmo_reg, tmo_next;

    logic        cmd_in_range;
    logic        accept;
    logic        reject;
    logic        tmr_hit;
    logic        amp_match;
    logic [15:0] ramp_amp;
    logic [16:0] amp_up;
    logic [16:0] amp_floor;

    assign cmd_in_range = (cmd_freq >= FREQ_MIN) && (cmd_freq <= FREQ_MAX) && (cmd_amp <= AMP_MAX);
    assign accept       = (state_reg == IDLE) && cmd_valid && cmd_in_range;
    assign reject       = (state_reg == IDLE) && cmd_valid && !cmd_in_range;
    assign tmr_hit      = (tmr_reg == TIMEOUT - 24'd1);
    assign amp_match    = (pend_amp_reg == amp_reg);

    // Ramp arithmetic is 17 bits wide so the step can never wrap past the target or below zero.
    assign amp_up    = {1'b0, amp_reg} + {1'b0, RAMP_STEP};
    assign amp_floor = {1'b0, pend_amp_reg} + {1'b0, RAMP_STEP};

    always_comb begin
        ramp_amp = pend_amp_reg;
        if (pend_amp_reg > amp_reg) begin
            if (amp_up < {1'b0, pend_amp_reg})
                ramp_amp = amp_up[15:0];
        end else begin
            if ({1'b0, amp_reg} > amp_floor)
                ramp_amp = amp_reg - RAMP_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            pend_freq_reg <= 16'd0;
            pend_amp_reg  <= 16'd0;
            tmr_reg       <= 24'd0;
            freq_reg      <= DEF_FREQ;
            amp_reg       <= DEF_AMP;
            ready_reg     <= 1'b1;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            drop_reg      <= 1'b0;
            tmo_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pend_freq_reg <= pend_freq_next;
            pend_amp_reg  <= pend_amp_next;
            tmr_reg       <= tmr_next;
            freq_reg      <= freq_next;
            amp_reg       <= amp_next;
            ready_reg     <= ready_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            drop_reg      <= drop_next;
            tmo_reg       <= tmo_next;
        end
    end

    // Next-state logic; a wrap takes priority over a timeout landing on the same cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept)
                    state_next = WAIT_WRAP;
            end
            WAIT_WRAP: begin
                if (wrap) begin
                    if (amp_match || (RAMP_STEP == 16'd0))
                        state_next = IDLE;
                    else
                        state_next = RAMP;
                end else if (tmr_hit) begin
                    state_next = IDLE;
                end
            end
            RAMP: begin
                if (wrap) begin
                    if (ramp_amp == pend_amp_reg)
                        state_next = IDLE;
                end else if (tmr_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pend_freq_next = pend_freq_reg;
        pend_amp_next  = pend_amp_reg;
        tmr_next       = tmr_reg;
        freq_next      = freq_reg;
        amp_next       = amp_reg;
        done_next      = 1'b0;
        tmo_next       = 1'b0;
        case (state_reg)
            IDLE: begin
                tmr_next = 24'd0;
                if (accept) begin
                    pend_freq_next = cmd_freq;
                    pend_amp_next  = cmd_amp;
                end
            end
            WAIT_WRAP: begin
                if (wrap) begin
                    tmr_next  = 24'd0;
                    freq_next = pend_freq_reg;
                    if (amp_match || (RAMP_STEP == 16'd0)) begin
                        amp_next  = pend_amp_reg;
                        done_next = 1'b1;
                    end
                end else if (tmr_hit) begin
                    tmr_next  = 24'd0;
                    freq_next = pend_freq_reg;
                    amp_next  = pend_amp_reg;
                    done_next = 1'b1;
                    tmo_next  = 1'b1;
                end else begin
                    tmr_next = tmr_reg + 24'd1;
                end
            end
            RAMP: begin
                if (wrap) begin
                    tmr_next = 24'd0;
                    amp_next = ramp_amp;
                    if (ramp_amp == pend_amp_reg)
                        done_next = 1'b1;
                end else if (tmr_hit) begin
                    tmr_next  = 24'd0;
                    freq_next = pend_freq_reg;
                    amp_next  = pend_amp_reg;
                    done_next = 1'b1;
                    tmo_next  = 1'b1;
                end else begin
                    tmr_next = tmr_reg + 24'd1;
                end
            end
            default: tmr_next = 24'd0;
        endcase
    end

    // Handshake and error flags are registered from the next state so they line up with it.
    always_comb begin
        ready_next = (state_next == IDLE);
        busy_next  = (state_next != IDLE);
        err_next   = reject;
        drop_next  = cmd_valid && (state_reg != IDLE);
    end

    assign cmd_ready = ready_reg;
    assign busy      = busy_reg;
    assign freq_out  = freq_reg;
    assign amp_out   = amp_reg;
    assign upd_done  = done_reg;
    assign cmd_err   = err_reg;
    assign cmd_drop  = drop_reg;
    assign tmo       = tmo_reg;

endmodule

// File: tb/tb_da_param_ctrl.sv
// Directed bench for da_param_ctrl: wrap-aligned updates, amplitude ramp, range rejects,
// timeout forcing, dropped commands, reset mid-ramp and a command coinciding with a wrap.
module tb_da_param_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [15:0] cmd_freq;
    logic [15:0] cmd_amp;
    logic        cmd_ready;
    logic        wrap;
    logic [15:0] freq_out;
    logic [15:0] amp_out;
    logic        busy;
    logic        upd_done;
    logic        cmd_err;
    logic        cmd_drop;
    logic        tmo;

    int checks   = 0;
    int failures = 0;

    da_param_ctrl #(.TIMEOUT(24'd100)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_freq  (cmd_freq),
        .cmd_amp   (cmd_amp),
        .cmd_ready (cmd_ready),
        .wrap      (wrap),
        .freq_out  (freq_out),
        .amp_out   (amp_out),
        .busy      (busy),
        .upd_done  (upd_done),
        .cmd_err   (cmd_err),
        .cmd_drop  (cmd_drop),
        .tmo       (tmo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [15:0] f, input logic [15:0] a,
                            input logic rdy, input logic bsy, input logic dn);
        chk({tag, ".freq"}, {16'd0, freq_out}, {16'd0, f});
        chk({tag, ".amp"}, {16'd0, amp_out}, {16'd0, a});
        chk({tag, ".ready"}, {31'd0, cmd_ready}, {31'd0, rdy});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, bsy});
        chk({tag, ".done"}, {31'd0, upd_done}, {31'd0, dn});
    endtask

    task automatic send(input logic [15:0] f, input logic [15:0] a);
        cmd_valid = 1'b1;
        cmd_freq  = f;
        cmd_amp   = a;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic pulse_wrap();
        wrap = 1'b1;
        tick();
        wrap = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_freq = 16'd0; cmd_amp = 16'd0; wrap = 1'b0;
        #1;
        tick();
        tick();
        chk_outs("reset", 16'd100, 16'd1, 1'b1, 1'b0, 1'b0);
        chk("reset.err", {31'd0, cmd_err}, 32'd0);
        chk("reset.tmo", {31'd0, tmo}, 32'd0);
        rst = 1'b0;
        tick();
        chk("post_reset.done", {31'd0, upd_done}, 32'd0);

        // 1: simple frequency update, amplitude unchanged
        send(16'd200, 16'd1);
        chk_outs("t1.accept", 16'd100, 16'd1, 1'b0, 1'b1, 1'b0);
        repeat (49) tick();
        chk("t1.hold.freq", {16'd0, freq_out}, 32'd100);
        pulse_wrap();
        chk_outs("t1.wrap", 16'd200, 16'd1, 1'b1, 1'b0, 1'b1);
        tick();
        chk("t1.done_width", {31'd0, upd_done}, 32'd0);

        // 2: amplitude ramp 1 -> 4
        send(16'd200, 16'd4);
        chk_outs("t2.accept", 16'd200, 16'd1, 1'b0, 1'b1, 1'b0);
        pulse_wrap();
        chk_outs("t2.wrap1", 16'd200, 16'd1, 1'b0, 1'b1, 1'b0);
        tick();
        pulse_wrap();
        chk_outs("t2.wrap2", 16'd200, 16'd2, 1'b0, 1'b1, 1'b0);
        tick();
        pulse_wrap();
        chk_outs("t2.wrap3", 16'd200, 16'd3, 1'b0, 1'b1, 1'b0);
        tick();
        pulse_wrap();
        chk_outs("t2.wrap4", 16'd200, 16'd4, 1'b1, 1'b0, 1'b1);
        tick();

        // 3: out-of-range commands
        send(16'd1001, 16'd2);
        chk("t3.freq_hi.err", {31'd0, cmd_err}, 32'd1);
        chk_outs("t3.freq_hi", 16'd200, 16'd4, 1'b1, 1'b0, 1'b0);
        tick();
        chk("t3.err_width", {31'd0, cmd_err}, 32'd0);
        send(16'd100, 16'd17);
        chk("t3.amp_hi.err", {31'd0, cmd_err}, 32'd1);
        chk_outs("t3.amp_hi", 16'd200, 16'd4, 1'b1, 1'b0, 1'b0);
        send(16'd0, 16'd0);
        chk("t3.freq_lo.err", {31'd0, cmd_err}, 32'd1);
        chk("t3.freq_lo.busy", {31'd0, busy}, 32'd0);
        tick();

        // 4: no wrap, timeout forces the update after 100 cycles
        send(16'd300, 16'd8);
        repeat (99) tick();
        chk_outs("t4.before", 16'd200, 16'd4, 1'b0, 1'b1, 1'b0);
        chk("t4.before.tmo", {31'd0, tmo}, 32'd0);
        tick();
        chk_outs("t4.forced", 16'd300, 16'd8, 1'b1, 1'b0, 1'b1);
        chk("t4.forced.tmo", {31'd0, tmo}, 32'd1);
        tick();
        chk("t4.tmo_width", {31'd0, tmo}, 32'd0);

        // 5: downward ramp 8 -> 5 with a dropped command, then reset mid-ramp
        send(16'd400, 16'd5);
        pulse_wrap();
        chk_outs("t5.wrap1", 16'd400, 16'd8, 1'b0, 1'b1, 1'b0);
        send(16'd900, 16'd2);
        chk("t5.drop", {31'd0, cmd_drop}, 32'd1);
        tick();
        chk("t5.drop_width", {31'd0, cmd_drop}, 32'd0);
        pulse_wrap();
        chk_outs("t5.wrap2", 16'd400, 16'd7, 1'b0, 1'b1, 1'b0);
        tick();
        pulse_wrap();
        chk_outs("t5.wrap3", 16'd400, 16'd6, 1'b0, 1'b1, 1'b0);
        tick();
        pulse_wrap();
        chk_outs("t5.wrap4", 16'd400, 16'd5, 1'b1, 1'b0, 1'b1);
        tick();
        send(16'd600, 16'd9);
        pulse_wrap();
        tick();
        pulse_wrap();
        chk_outs("t5.ramp2", 16'd600, 16'd6, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        chk_outs("t5.rst", 16'd100, 16'd1, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_outs("t5.after_rst", 16'd100, 16'd1, 1'b1, 1'b0, 1'b0);

        // 6: command coinciding with a wrap waits for the following wrap
        wrap = 1'b1;
        send(16'd500, 16'd1);
        wrap = 1'b0;
        chk_outs("t6.accept", 16'd100, 16'd1, 1'b0, 1'b1, 1'b0);
        repeat (3) tick();
        chk("t6.hold.freq", {16'd0, freq_out}, 32'd100);
        pulse_wrap();
        chk_outs("t6.wrap", 16'd500, 16'd1, 1'b1, 1'b0, 1'b1);
        tick();
        chk("t6.done_width", {31'd0, upd_done}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
